// File: rtl/dynamic_display_driver.sv
// Multiplexed 4-digit common-anode 7-segment driver with frame-synchronous
// value commit, anti-ghosting blank gaps and optional leading-zero blanking.
module dynamic_display_driver #(
  parameter int BLANK_CYCLES = 4,
  parameter bit LZ_BLANK_EN  = 1'b1
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [1:0]  S_CLK,
  input  logic [15:0] DATA,
  input  logic [3:0]  DP,
  input  logic        LOAD,
  output logic        BUSY,
  output logic [3:0]  AN,
  output logic [7:0]  SEG,
  output logic        FRAME
);

  localparam logic       ST_BLANK = 1'b0;
  localparam logic       ST_SHOW  = 1'b1;
  localparam logic [7:0] CNT_LAST = 8'(BLANK_CYCLES - 1);

  logic        state_r;
  logic [7:0]  cnt_r;
  logic [1:0]  s_q_r;
  logic [15:0] pend_data_r;
  logic [3:0]  pend_dp_r;
  logic [15:0] disp_data_r;
  logic [3:0]  disp_dp_r;

  logic        change_s;
  logic        to_zero_s;
  logic        commit_s;
  logic [3:0]  nib_s;
  logic [6:0]  glyph_s;
  logic [3:0]  an_digit_s;
  logic [7:0]  seg_digit_s;

  function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'h0: g = 7'h40;
      4'h1: g = 7'h79;
      4'h2: g = 7'h24;
      4'h3: g = 7'h30;
      4'h4: g = 7'h19;
      4'h5: g = 7'h12;
      4'h6: g = 7'h02;
      4'h7: g = 7'h78;
      4'h8: g = 7'h00;
      4'h9: g = 7'h10;
      4'hA: g = 7'h08;
      4'hB: g = 7'h03;
      4'hC: g = 7'h46;
      4'hD: g = 7'h21;
      4'hE: g = 7'h06;
      4'hF: g = 7'h0E;
      default: g = 7'h7F;
    endcase
    return g;
  endfunction

  // A digit is a leading zero only if it and every more significant nibble are zero.
  function automatic logic lz_hide(input logic [15:0] val, input logic [1:0] idx);
    logic hide;
    case (idx)
      2'd1:    hide = (val[15:4] == 12'h000);
      2'd2:    hide = (val[15:8] == 8'h00);
      2'd3:    hide = (val[15:12] == 4'h0);
      default: hide = 1'b0;
    endcase
    return hide && LZ_BLANK_EN;
  endfunction

  // Change detection and digit pattern for the currently selected digit
  always_comb begin
    change_s    = (S_CLK != s_q_r);
    to_zero_s   = change_s && (S_CLK == 2'd0);
    commit_s    = to_zero_s && BUSY;
    nib_s       = disp_data_r[{s_q_r, 2'b00} +: 4];
    if (lz_hide(disp_data_r, s_q_r)) begin
      glyph_s = 7'h7F;
    end else begin
      glyph_s = hex_glyph(nib_s);
    end
    seg_digit_s = {~disp_dp_r[s_q_r], glyph_s};
    an_digit_s  = ~(4'b0001 << s_q_r);
  end

  // Blank/show sequencing, value capture/commit and registered outputs
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_r     <= ST_BLANK;
      cnt_r       <= 8'd0;
      s_q_r       <= 2'd0;
      pend_data_r <= 16'h0000;
      pend_dp_r   <= 4'h0;
      disp_data_r <= 16'h0000;
      disp_dp_r   <= 4'h0;
      BUSY        <= 1'b0;
      FRAME       <= 1'b0;
      AN          <= 4'hF;
      SEG         <= 8'hFF;
    end else begin
      s_q_r <= S_CLK;
      FRAME <= to_zero_s;
      // Non-blocking order lets a coincident LOAD commit the older pending value
      if (commit_s) begin
        disp_data_r <= pend_data_r;
        disp_dp_r   <= pend_dp_r;
      end
      if (LOAD) begin
        pend_data_r <= DATA;
        pend_dp_r   <= DP;
        BUSY        <= 1'b1;
      end else if (commit_s) begin
        BUSY <= 1'b0;
      end
      if (change_s) begin
        state_r <= ST_BLANK;
        cnt_r   <= 8'd0;
        AN      <= 4'hF;
        SEG     <= 8'hFF;
      end else begin
        case (state_r)
          ST_BLANK: begin
            if (cnt_r == CNT_LAST) begin
              state_r <= ST_SHOW;
              AN      <= an_digit_s;
              SEG     <= seg_digit_s;
            end else begin
              cnt_r <= cnt_r + 8'd1;
            end
          end
          ST_SHOW: begin
            state_r <= ST_SHOW;
          end
          default: begin
            state_r <= ST_BLANK;
            cnt_r   <= 8'd0;
            AN      <= 4'hF;
            SEG     <= 8'hFF;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dynamic_display_driver.sv
// Scoreboard bench for dynamic_display_driver: stimulus pushes hand-computed
// per-cycle expectations, a negedge monitor pops and compares them.
module tb_dynamic_display_driver;

  logic        clk;
  logic        rst_n;
  logic [1:0]  s_clk;
  logic [15:0] data;
  logic [3:0]  dp;
  logic        load;
  logic        busy;
  logic [3:0]  an;
  logic [7:0]  seg;
  logic        frame;

  int cyc;
  int checks;
  int failures;

  typedef struct {
    int          cyc;
    logic [3:0]  an;
    logic [7:0]  seg;
    logic        busy;
    logic        frame;
    string       name;
  } exp_t;

  exp_t exp_q[$];

  dynamic_display_driver #(.BLANK_CYCLES(4), .LZ_BLANK_EN(1'b1)) dut (
    .CLK(clk), .RST_N(rst_n), .S_CLK(s_clk), .DATA(data), .DP(dp),
    .LOAD(load), .BUSY(busy), .AN(an), .SEG(seg), .FRAME(frame)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every expectation tagged for the current cycle
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      exp_t e;
      e = exp_q.pop_front();
      checks = checks + 1;
      if (e.cyc != cyc || an !== e.an || seg !== e.seg || busy !== e.busy || frame !== e.frame) begin
        failures = failures + 1;
        $display("FAIL %s cyc=%0d: got an=%h seg=%h busy=%b frame=%b, want an=%h seg=%h busy=%b frame=%b (tag %0d)",
                 e.name, cyc, an, seg, busy, frame, e.an, e.seg, e.busy, e.frame, e.cyc);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_now(input string nm, input logic [3:0] a, input logic [7:0] s,
                            input logic b, input logic f);
    exp_t e;
    e.cyc = cyc; e.an = a; e.seg = s; e.busy = b; e.frame = f; e.name = nm;
    exp_q.push_back(e);
  endtask

  // Move to digit sel (optionally loading), check 4 blank cycles, the lit digit, and hold
  task automatic visit(input logic [1:0] sel, input logic [7:0] seg_e, input logic busy_e,
                       input logic frame_e, input logic do_load, input logic [15:0] d,
                       input logic [3:0] dpi, input string nm);
    logic [3:0] an_e;
    an_e  = ~(4'b0001 << sel);
    s_clk = sel;
    if (do_load) begin
      load = 1'b1; data = d; dp = dpi;
    end
    step(1);
    expect_now({nm, "_chg"}, 4'hF, 8'hFF, busy_e, frame_e);
    load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1);
      expect_now({nm, "_blank"}, 4'hF, 8'hFF, busy_e, 1'b0);
    end
    step(1);
    expect_now({nm, "_show"}, an_e, seg_e, busy_e, 1'b0);
    step(3);
    expect_now({nm, "_hold"}, an_e, seg_e, busy_e, 1'b0);
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] dpi,
                         input logic [3:0] an_e, input logic [7:0] seg_e, input string nm);
    load = 1'b1; data = d; dp = dpi;
    step(1);
    expect_now(nm, an_e, seg_e, 1'b1, 1'b0);
    load = 1'b0;
  endtask

  initial begin
    cyc = 0; checks = 0; failures = 0;
    rst_n = 1'b0; s_clk = 2'd0; data = 16'h0000; dp = 4'h0; load = 1'b0;
    #1;
    // 1: reset, S_CLK at 0, digit 0 shows "0" after 4 blank cycles
    step(1);
    expect_now("rst", 4'hF, 8'hFF, 1'b0, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1);
      expect_now("rst_blank", 4'hF, 8'hFF, 1'b0, 1'b0);
    end
    step(1);
    expect_now("rst_show", 4'hE, 8'hC0, 1'b0, 1'b0);

    // 2: load 12AF, sweep; old (zero) display shown until the wrap commits
    do_load(16'h12AF, 4'b0100, 4'hE, 8'hC0, "load_12af");
    visit(2'd1, 8'hFF, 1'b1, 1'b0, 1'b0, 16'h0, 4'h0, "t2_d1_old");
    visit(2'd2, 8'hFF, 1'b1, 1'b0, 1'b0, 16'h0, 4'h0, "t2_d2_old");
    visit(2'd3, 8'hFF, 1'b1, 1'b0, 1'b0, 16'h0, 4'h0, "t2_d3_old");
    visit(2'd0, 8'h8E, 1'b0, 1'b1, 1'b0, 16'h0, 4'h0, "t2_d0_new");
    visit(2'd1, 8'h88, 1'b0, 1'b0, 1'b0, 16'h0, 4'h0, "t2_d1_new");
    visit(2'd2, 8'h24, 1'b0, 1'b0, 1'b0, 16'h0, 4'h0, "t2_d2_new");
    visit(2'd3, 8'hF9, 1'b0, 1'b0, 1'b0, 16'h0, 4'h0, "t2_d3_new");
    visit(2'd0, 8'h8E, 1'b0, 1'b1, 1'b0, 16'h0, 4'h0, "t2_d0_again");

    // 3: leading-zero suppression
    do_load(16'h0005, 4'h0, 4'hE, 8'h8E, "load_0005");
    visit(2'd1, 8'h88, 1'b1, 1'b0, 1'b0, 16'h0, 4'h0, "t3_d1_old");
    visit(2'd2, 8'h24, 1'b1, 1'b0, 1'b0, 16'h0, 4'h0, "t3_d2_old");
    visit(2'd3, 8'hF9, 1'b1, 1'b0, 1'b0, 16'h0, 4'h0, "t3_d3_old");
    visit(2'd0, 8'h92, 1'b0, 1'b1, 1'b0, 16'h0, 4'h0, "t3_0005_d0");
    visit(2'd1, 8'hFF, 1'b0, 1'b0, 1'b0, 16'h0, 4'h0, "t3_0005_d1");
    visit(2'd2, 8'hFF, 1'b0, 1'b0, 1'b0, 16'h0, 4'h0, "t3_0005_d2");
    visit(2'd3, 8'hFF, 1'b0, 1'b0, 1'b0, 16'h0, 4'h0, "t3_0005_d3");
    do_load(16'h0105, 4'h0, 4'h7, 8'hFF, "load_0105");
    visit(2'd0, 8'h92, 1'b0, 1'b1, 1'b0, 16'h0, 4'h0, "t3_0105_d0");
    visit(2'd1, 8'hC0, 1'b0, 1'b0, 1'b0, 16'h0, 4'h0, "t3_0105_d1");
    visit(2'd2, 8'hF9, 1'b0, 1'b0, 1'b0, 16'h0, 4'h0, "t3_0105_d2");
    visit(2'd3, 8'hFF, 1'b0, 1'b0, 1'b0, 16'h0, 4'h0, "t3_0105_d3");

    // 4: latest pending wins; load on the commit cycle keeps BUSY
    do_load(16'h1111, 4'h0, 4'h7, 8'hFF, "load_1111");
    do_load(16'h2222, 4'h0, 4'h7, 8'hFF, "load_2222");
    visit(2'd0, 8'hA4, 1'b1, 1'b1, 1'b1, 16'h3333, 4'h0, "t4_commit_2222");
    visit(2'd1, 8'hA4, 1'b1, 1'b0, 1'b0, 16'h0, 4'h0, "t4_d1");
    visit(2'd2, 8'hA4, 1'b1, 1'b0, 1'b0, 16'h0, 4'h0, "t4_d2");
    visit(2'd3, 8'hA4, 1'b1, 1'b0, 1'b0, 16'h0, 4'h0, "t4_d3");
    visit(2'd0, 8'hB0, 1'b0, 1'b1, 1'b0, 16'h0, 4'h0, "t4_commit_3333");

    // 5: changes during blank restart the count
    s_clk = 2'd1;
    for (int i = 0; i < 3; i++) begin
      step(1);
      expect_now("t5_blank_a", 4'hF, 8'hFF, 1'b0, 1'b0);
    end
    s_clk = 2'd2;
    step(1);
    expect_now("t5_chg2", 4'hF, 8'hFF, 1'b0, 1'b0);
    s_clk = 2'd3;
    step(1);
    expect_now("t5_chg3", 4'hF, 8'hFF, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1);
      expect_now("t5_blank_b", 4'hF, 8'hFF, 1'b0, 1'b0);
    end
    step(1);
    expect_now("t5_show", 4'h7, 8'hB0, 1'b0, 1'b0);
    step(20);
    expect_now("t5_hold", 4'h7, 8'hB0, 1'b0, 1'b0);

    // 6: reset mid-SHOW discards pending and display
    do_load(16'h4444, 4'hF, 4'h7, 8'hB0, "load_4444");
    rst_n = 1'b0; s_clk = 2'd0;
    step(1);
    expect_now("t6_rst", 4'hF, 8'hFF, 1'b0, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1);
      expect_now("t6_blank", 4'hF, 8'hFF, 1'b0, 1'b0);
    end
    step(1);
    expect_now("t6_show", 4'hE, 8'hC0, 1'b0, 1'b0);
    visit(2'd1, 8'hFF, 1'b0, 1'b0, 1'b0, 16'h0, 4'h0, "t6_d1");
    visit(2'd0, 8'hC0, 1'b0, 1'b1, 1'b0, 16'h0, 4'h0, "t6_d0_nocommit");

    step(2);
    checks = checks + 1;
    if (exp_q.size() != 0) begin
      failures = failures + 1;
      $display("FAIL scoreboard_drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
